// File: rtl/seq_addsub.sv
// Multi-cycle two's-complement adder/subtractor: N bits processed K bits per clock
// through a registered inter-slice carry. Define ADDSUB_SAT_EN to saturate s on overflow.
module seq_addsub #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         sub_i,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [N-1:0] s_o,
  output logic         cout_o,
  output logic         ovf_o,
  output logic         zero_o
);

  localparam int S  = (K > 0) ? (N / K) : 1;
  localparam int IW = (S > 1) ? $clog2(S) : 1;
  localparam logic [IW-1:0] LAST = IW'(S - 1);

  if ((K < 1) || (N < 4) || (N > 256) || ((N % K) != 0)) begin : g_bad_param
    $fatal(1, "seq_addsub: illegal parameters N=%0d K=%0d", N, K);
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q;
  logic [N-1:0]    a_q;
  logic [N-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx_q;
  logic [N-1:0]    s_q;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;
  logic            busy_q;
  logic            done_q;

  logic [K:0]      sum_d;
  logic [N-1:0]    a_d;
  logic            c_msb_d;
  logic            ovf_d;
  logic [N-1:0]    res_d;
  logic            zero_d;

  // Slice adder. a_q doubles as the result accumulator: the consumed slice leaves at the
  // bottom while the new sum bits enter at the top, so after N/K shifts a_q holds the sum
  // and the current slice is always a_q/b_q[K-1:0] (the MSB slice on the last step).
  always_comb begin
    sum_d   = {1'b0, a_q[K-1:0]} + {1'b0, b_q[K-1:0]} + {{K{1'b0}}, carry_q};
    a_d     = N'({sum_d[K-1:0], a_q} >> K);
    c_msb_d = a_q[K-1] ^ b_q[K-1] ^ sum_d[K-1];
    ovf_d   = c_msb_d ^ sum_d[K];
`ifdef ADDSUB_SAT_EN
    if (ovf_d) begin
      if (a_q[K-1]) begin
        res_d = {1'b1, {(N-1){1'b0}}};
      end else begin
        res_d = {1'b0, {(N-1){1'b1}}};
      end
    end else begin
      res_d = a_d;
    end
`else
    res_d = a_d;
`endif
    zero_d  = (res_d == {N{1'b0}});
  end

  // Control FSM with registered handshake, result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      a_q     <= {N{1'b0}};
      b_q     <= {N{1'b0}};
      carry_q <= 1'b0;
      idx_q   <= {IW{1'b0}};
      s_q     <= {N{1'b0}};
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q     <= a_i;
            b_q     <= b_i ^ {N{sub_i}};
            carry_q <= sub_i;
            idx_q   <= {IW{1'b0}};
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_q     <= a_d;
          b_q     <= b_q >> K;
          carry_q <= sum_d[K];
          if (idx_q == LAST) begin
            idx_q   <= {IW{1'b0}};
            s_q     <= res_d;
            cout_q  <= sum_d[K];
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else begin
            idx_q   <= idx_q + IW'(1);
            done_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign s_o    = s_q;
  assign cout_o = cout_q;
  assign ovf_o  = ovf_q;
  assign zero_o = zero_q;

endmodule

// File: tb/tb_seq_addsub.sv
// Directed and randomised checks of seq_addsub at N=8/K=4, N=16/K=16 and N=256/K=8.
module tb_seq_addsub;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  logic st8, sb8, bz8, dn8, co8, ov8, zr8;
  logic [7:0] a8, b8, s8;
  logic st16, sb16, bz16, dn16, co16, ov16, zr16;
  logic [15:0] a16, b16, s16;
  logic st256, sb256, bz256, dn256, co256, ov256, zr256;
  logic [255:0] a256, b256, s256;
  logic [2:0] done_v;

  assign done_v = {dn256, dn16, dn8};

  always #5 clk = ~clk;

  seq_addsub #(.N(8), .K(4)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(st8), .sub_i(sb8), .a_i(a8), .b_i(b8),
    .busy_o(bz8), .done_o(dn8), .s_o(s8), .cout_o(co8), .ovf_o(ov8), .zero_o(zr8));

  seq_addsub #(.N(16), .K(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start_i(st16), .sub_i(sb16), .a_i(a16), .b_i(b16),
    .busy_o(bz16), .done_o(dn16), .s_o(s16), .cout_o(co16), .ovf_o(ov16), .zero_o(zr16));

  seq_addsub #(.N(256), .K(8)) u_dut256 (
    .clk(clk), .rst_n(rst_n), .start_i(st256), .sub_i(sb256), .a_i(a256), .b_i(b256),
    .busy_o(bz256), .done_o(dn256), .s_o(s256), .cout_o(co256), .ovf_o(ov256), .zero_o(zr256));

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles counted from the negedge right after the accept edge until done is seen.
  task automatic wait_done(input int which, output int cnt);
    cnt = 0;
    @(negedge clk);
    while (done_v[which] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic sub,
                     input logic [7:0] es, input logic ec, input logic eo, input logic ez);
    int cnt;
    a8 = a; b8 = b; sb8 = sub; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    wait_done(0, cnt);
    chk({tag, "_lat"}, 256'(cnt), 256'd2);
    chk({tag, "_s"}, 256'(s8), 256'(es));
    chk({tag, "_cout"}, 256'(co8), 256'(ec));
    chk({tag, "_ovf"}, 256'(ov8), 256'(eo));
    chk({tag, "_zero"}, 256'(zr8), 256'(ez));
    chk({tag, "_busy"}, 256'(bz8), 256'd0);
  endtask

  function automatic void model(input int n, input logic [255:0] a, input logic [255:0] b,
                                input logic sub, output logic [255:0] s, output logic c,
                                output logic o, output logic z);
    logic [256:0] mask, full;
    logic [255:0] am, bb, r;
    mask = (257'd1 << n) - 257'd1;
    am   = a & mask[255:0];
    bb   = (sub ? ~b : b) & mask[255:0];
    full = {1'b0, am} + {1'b0, bb} + {256'd0, sub};
    r    = full[255:0] & mask[255:0];
    c    = full[n];
    o    = (am[n-1] == bb[n-1]) && (r[n-1] != am[n-1]);
    if (SAT && o) s = am[n-1] ? (256'd1 << (n - 1)) : ((256'd1 << (n - 1)) - 256'd1);
    else s = r;
    z = (s == 256'd0);
  endfunction

  task automatic big(input int which, input logic [255:0] a, input logic [255:0] b, input logic sub);
    logic [255:0] es, obs_s;
    logic ec, eo, ez, obs_c, obs_o, obs_z;
    int cnt, n, lat;
    n   = (which == 1) ? 16 : 256;
    lat = (which == 1) ? 1 : 32;
    model(n, a, b, sub, es, ec, eo, ez);
    if (which == 1) begin
      a16 = a[15:0]; b16 = b[15:0]; sb16 = sub; st16 = 1'b1;
    end else begin
      a256 = a; b256 = b; sb256 = sub; st256 = 1'b1;
    end
    @(posedge clk);
    #1 st16 = 1'b0; st256 = 1'b0;
    wait_done(which, cnt);
    obs_s = (which == 1) ? 256'(s16) : s256;
    obs_c = (which == 1) ? co16 : co256;
    obs_o = (which == 1) ? ov16 : ov256;
    obs_z = (which == 1) ? zr16 : zr256;
    chk("rnd_lat", 256'(cnt), 256'(lat));
    chk("rnd_s", obs_s, es);
    chk("rnd_cout", 256'(obs_c), 256'(ec));
    chk("rnd_ovf", 256'(obs_o), 256'(eo));
    chk("rnd_zero", 256'(obs_z), 256'(ez));
  endtask

  initial begin
    logic [255:0] ra, rb;
    logic rs;
    rst_n = 1'b0;
    st8 = 1'b0; sb8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    st16 = 1'b0; sb16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    st256 = 1'b0; sb256 = 1'b0; a256 = 256'd0; b256 = 256'd0;
    #12;
    chk("rst_busy", 256'(bz8), 256'd0);
    chk("rst_done", 256'(dn8), 256'd0);
    chk("rst_s", 256'(s8), 256'd0);
    chk("rst_cout", 256'(co8), 256'd0);
    chk("rst_ovf", 256'(ov8), 256'd0);
    chk("rst_zero", 256'(zr8), 256'd1);
    @(negedge clk);
    rst_n = 1'b1;

    op8("add", 8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0);
    op8("sub_neg", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0);
    op8("sub_eq", 8'h2A, 8'h2A, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("add_ovf", 8'h7F, 8'h01, 1'b0, SAT ? 8'h7F : 8'h80, 1'b0, 1'b1, 1'b0);
    op8("sub_ovf", 8'h80, 8'h01, 1'b1, SAT ? 8'h80 : 8'h7F, 1'b1, 1'b1, 1'b0);
    op8("add_wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op8("neg_ovf", 8'h80, 8'h80, 1'b0, 8'h80 & {8{SAT}}, 1'b1, 1'b1, !SAT);

    // start held high: accept in every DONE cycle, period N/K + 1
    a8 = 8'h10; b8 = 8'h01; sb8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    for (int p = 0; p < 7; p++) begin
      @(negedge clk);
      chk("hold_done", 256'(dn8), 256'((p == 2) || (p == 5)));
      chk("hold_busy", 256'(bz8), 256'((p < 6) && (p % 3 != 2)));
      if (p == 2) begin
        chk("hold_s1", 256'(s8), 256'h11);
        a8 = 8'h20;
      end
      if (p == 5) begin
        chk("hold_s2", 256'(s8), 256'h21);
        st8 = 1'b0;
      end
    end

    // start pulsed during RUN is ignored
    a8 = 8'h01; b8 = 8'h02; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      if (p == 0) begin
        chk("ign_s0", 256'(s8), 256'h21);
        st8 = 1'b1; a8 = 8'h55; b8 = 8'h11;
      end
      if (p == 1) begin
        chk("ign_s1", 256'(s8), 256'h21);
        st8 = 1'b0;
      end
      if (p == 2) begin
        chk("ign_done", 256'(dn8), 256'd1);
        chk("ign_s2", 256'(s8), 256'h03);
      end
      if (p == 3) begin
        chk("ign_busy", 256'(bz8), 256'd0);
        chk("ign_nodone", 256'(dn8), 256'd0);
      end
    end

    // reset asserted in the first RUN cycle aborts the operation
    a8 = 8'h3C; b8 = 8'h05; sb8 = 1'b0; st8 = 1'b1;
    @(posedge clk);
    #1 st8 = 1'b0;
    @(negedge clk);
    chk("abort_run", 256'(bz8), 256'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 256'(bz8), 256'd0);
    chk("abort_done", 256'(dn8), 256'd0);
    chk("abort_s", 256'(s8), 256'd0);
    chk("abort_zero", 256'(zr8), 256'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      chk("abort_nodone", 256'(dn8), 256'd0);
    end
    op8("post_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rs = 1'($urandom_range(0, 1));
      if (i % 16 == 0) begin
        rb = ra; rs = 1'b1;
      end
      big(1, ra, rb, rs);
    end
    for (int i = 0; i < 300; i++) begin
      for (int w = 0; w < 8; w++) begin
        ra[w*32 +: 32] = $urandom;
        rb[w*32 +: 32] = $urandom;
      end
      rs = 1'($urandom_range(0, 1));
      if (i % 16 == 0) begin
        rb = ra; rs = 1'b1;
      end
      big(2, ra, rb, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
